alu_operand_sequencer: RTL and testbench

//  Front-end controller for the NBITS-wide ALU on the board. Loads operand A, then

---
 rtl/alu_operand_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand/op-code loader and result register around a combinational ALU.
// Optional button debouncing is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer #(
   parameter int NBITS           = 8,
   parameter int COD_OP          = 6,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NBITS-1:0]  i_switches,
   input  logic              i_btn_a,
   input  logic              i_btn_b,
   input  logic              i_btn_op,
   input  logic              i_btn_run,
   output logic [NBITS-1:0]  operando_A,
   output logic [NBITS-1:0]  operando_B,
   output logic [COD_OP-1:0] cod_operacion,
   input  logic [NBITS-1:0]  ALU_Result,
   output logic [NBITS-1:0]  o_result,
   output logic              o_valid,
   output logic              o_error,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      READY   = 3'd3,
      EXEC    = 3'd4,
      DONE    = 3'd5
   } state_t;

   function automatic logic is_supported(input logic [COD_OP-1:0] code);
      case (code)
         COD_OP'(6'b100000), COD_OP'(6'b100010), COD_OP'(6'b100100),
         COD_OP'(6'b100101), COD_OP'(6'b100110), COD_OP'(6'b000011),
         COD_OP'(6'b000010), COD_OP'(6'b100111): is_supported = 1'b1;
         default:                                 is_supported = 1'b0;
      endcase
   endfunction

   // Button order in all per-button vectors: {run, op, b, a}
   logic [3:0] raw;
   logic [3:0] sync1, sync2, level, prev, armed, pulse;
   logic [1:0] fill;

   assign raw = {i_btn_run, i_btn_op, i_btn_b, i_btn_a};

   // A button is armed only after it has been seen released once the synchroniser
   // holds real samples, so a button held through reset release never pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         fill  <= '0;
         armed <= '0;
         prev  <= '0;
         pulse <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
         armed <= armed | ({4{fill[1]}} & ~sync2);
         prev  <= level;
         pulse <= level & ~prev & armed;
      end
   end

`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   logic [3:0]    filt;
   logic [CW-1:0] cnt [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               filt[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign level = filt;
`else
   assign level = sync2;
`endif

   state_t             state, state_n;
   logic [NBITS-1:0]   a_r, a_n, b_r, b_n, result_n;
   logic [COD_OP-1:0]  op_r, op_n;
   logic               valid_n, error_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= '0;
         o_result <= '0;
         o_valid  <= 1'b0;
         o_error  <= 1'b0;
      end else begin
         state    <= state_n;
         a_r      <= a_n;
         b_r      <= b_n;
         op_r     <= op_n;
         o_result <= result_n;
         o_valid  <= valid_n;
         o_error  <= error_n;
      end
   end

   always_comb begin
      state_n  = state;
      a_n      = a_r;
      b_n      = b_r;
      op_n     = op_r;
      result_n = o_result;
      valid_n  = o_valid;
      error_n  = o_error;
      case (state)
         IDLE: begin
            if (pulse[0]) begin
               a_n     = i_switches;
               valid_n = 1'b0;
               error_n = 1'b0;
               state_n = WAIT_B;
            end
         end
         WAIT_B: begin
            if (pulse[1]) begin
               b_n     = i_switches;
               state_n = WAIT_OP;
            end
         end
         WAIT_OP: begin
            if (pulse[2]) begin
               if (is_supported(i_switches[COD_OP-1:0])) begin
                  op_n    = i_switches[COD_OP-1:0];
                  error_n = 1'b0;
                  state_n = READY;
               end else begin
                  error_n = 1'b1;
               end
            end
         end
         READY: begin
            if (pulse[3]) state_n = EXEC;
         end
         EXEC: begin
            result_n = ALU_Result;
            valid_n  = 1'b1;
            state_n  = DONE;
         end
         DONE: begin
            // A new load takes precedence over a re-run pressed in the same cycle
            if (pulse[0]) begin
               a_n     = i_switches;
               valid_n = 1'b0;
               error_n = 1'b0;
               state_n = WAIT_B;
            end else if (pulse[3]) begin
               state_n = EXEC;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign operando_A    = a_r;
   assign operando_B    = b_r;
   assign cod_operacion = (state == EXEC || state == DONE) ? op_r : '0;
   assign o_state       = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: vector table, corner sequences, random runs.
module tb_alu_operand_sequencer;
   localparam int NBITS  = 8;
   localparam int COD_OP = 6;
`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   localparam int HOLD   = DB + 2;
   localparam int SETTLE = DB + 8;

   localparam logic [3:0] BA = 4'b0001, BB = 4'b0010, BO = 4'b0100, BR = 4'b1000;

   logic              clk, rst_n;
   logic [NBITS-1:0]  sw;
   logic [3:0]        btn;
   logic [NBITS-1:0]  op_a, op_b, alu_res, o_result;
   logic [COD_OP-1:0] cod;
   logic              o_valid, o_error;
   logic [2:0]        o_state;

   int checks   = 0;
   int failures = 0;

   logic [5:0] codes [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100110, 6'b000011, 6'b000010, 6'b100111};

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      case (op)
         6'b100000: alu_ref = a + b;
         6'b100010: alu_ref = a - b;
         6'b100100: alu_ref = a & b;
         6'b100101: alu_ref = a | b;
         6'b100110: alu_ref = a ^ b;
         6'b000011: alu_ref = $unsigned($signed(a) >>> b);
         6'b000010: alu_ref = a >> b;
         6'b100111: alu_ref = ~(a | b);
         default:   alu_ref = 8'h00;
      endcase
   endfunction

   function automatic logic supported(input logic [5:0] op);
      supported = 1'b0;
      for (int i = 0; i < 8; i++) if (codes[i] == op) supported = 1'b1;
   endfunction

   // Behavioural ALU attached to the sequencer outputs
   assign alu_res = alu_ref(op_a, op_b, cod);

   alu_operand_sequencer #(.NBITS(NBITS), .COD_OP(COD_OP), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_switches(sw),
      .i_btn_a(btn[0]), .i_btn_b(btn[1]), .i_btn_op(btn[2]), .i_btn_run(btn[3]),
      .operando_A(op_a), .operando_B(op_b), .cod_operacion(cod), .ALU_Result(alu_res),
      .o_result(o_result), .o_valid(o_valid), .o_error(o_error), .o_state(o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] mask);
      @(posedge clk); #1 btn = mask;
      repeat (HOLD) @(posedge clk);
      #1 btn = 4'b0;
      repeat (SETTLE) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] res;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [7:0] a, b, exp_res;
      logic [5:0] op;
      logic       seen, ready;

      tbl[0] = '{8'h04, 8'h0C, 6'b100000, 8'h10};
      tbl[1] = '{8'h04, 8'h0C, 6'b100010, 8'hF8};
      tbl[2] = '{8'h0C, 8'h02, 6'b000011, 8'h03};
      tbl[3] = '{8'h04, 8'h0C, 6'b100111, 8'hF3};
      tbl[4] = '{8'h04, 8'h0C, 6'b100100, 8'h04};
      tbl[5] = '{8'hA5, 8'h0F, 6'b100110, 8'hAA};
      tbl[6] = '{8'h90, 8'h03, 6'b000010, 8'h12};
      tbl[7] = '{8'h90, 8'h03, 6'b000011, 8'hF2};

      btn = 4'b0; sw = '0; rst_n = 1'b0;
      #2;
      chk("rst_state", o_state, 0);
      chk("rst_result", o_result, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_error", o_error, 0);
      chk("rst_opa", op_a, 0);
      chk("rst_cod", cod, 0);
      do_reset();

      for (int i = 0; i < 8; i++) begin
         sw = tbl[i].a;  press(BA);
         chk("tbl_state_b", o_state, 1);
         chk("tbl_valid_clr", o_valid, 0);
         sw = tbl[i].b;  press(BB);
         chk("tbl_state_op", o_state, 2);
         chk("tbl_cod_idle", cod, 0);
         sw = {2'b00, tbl[i].op}; press(BO);
         chk("tbl_state_ready", o_state, 3);
         chk("tbl_error", o_error, 0);
         chk("tbl_cod_ready", cod, 0);
         sw = 8'hFF; press(BR);
         chk("tbl_state_done", o_state, 5);
         chk("tbl_valid", o_valid, 1);
         chk("tbl_result", o_result, tbl[i].res);
         chk("tbl_cod_done", cod, tbl[i].op);
         chk("tbl_opa", op_a, tbl[i].a);
         chk("tbl_opb", op_b, tbl[i].b);
      end

      // Re-run from DONE uses latched operands, not the switches
      sw = 8'h04; press(BA); sw = 8'h0C; press(BB); sw = 8'h22; press(BO); press(BR);
      chk("sub_result", o_result, 8'hF8);
      sw = 8'h77; press(BR);
      chk("rerun_result", o_result, 8'hF8);
      chk("rerun_valid", o_valid, 1);
      chk("rerun_state", o_state, 5);

      // Unsupported op code then recovery
      sw = 8'h04; press(BA); sw = 8'h0C; press(BB);
      sw = 8'h3F; press(BO);
      chk("inv_error", o_error, 1);
      chk("inv_state", o_state, 2);
      sw = 8'h24; press(BO);
      chk("inv_recover_err", o_error, 0);
      chk("inv_recover_st", o_state, 3);
      press(BR);
      chk("inv_and_result", o_result, 8'h04);

      // Out-of-order and simultaneous presses
      do_reset();
      press(BR);
      chk("ord_run_idle", o_state, 0);
      press(BB);
      chk("ord_b_idle", o_state, 0);
      sw = 8'h3C; press(BA | BB);
      chk("ord_ab_state", o_state, 1);
      chk("ord_ab_a", op_a, 8'h3C);
      chk("ord_ab_b", op_b, 8'h00);
      sw = 8'h11; press(BB);
      chk("ord_b_after", op_b, 8'h11);

      // Reset asserted while in EXEC
      sw = 8'h20; press(BO); press(BR);
      sw = 8'h55; press(BA); sw = 8'h0F; press(BB); sw = 8'h20; press(BO);
      @(posedge clk); #1 btn = BR;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_state == 3'd4) begin
            seen = 1'b1;
            break;
         end
      end
      chk("exec_reached", seen, 1);
      rst_n = 1'b0;
      #1;
      chk("exec_rst_state", o_state, 0);
      chk("exec_rst_result", o_result, 0);
      chk("exec_rst_valid", o_valid, 0);
      chk("exec_rst_opa", op_a, 0);
      chk("exec_rst_opb", op_b, 0);
      chk("exec_rst_cod", cod, 0);

      // Button held through reset release
      btn = BA; sw = 8'h66;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (DB + 12) @(posedge clk);
      @(negedge clk);
      chk("held_no_pulse", o_state, 0);
      #1 btn = 4'b0;
      repeat (SETTLE) @(posedge clk);
      press(BA);
      chk("held_repress", o_state, 1);
      chk("held_repress_a", op_a, 8'h66);

      // Randomized operand sets from DONE or WAIT_B
      do_reset();
      for (int n = 0; n < 25; n++) begin
         a = 8'($urandom); b = 8'($urandom);
         sw = a; press(BA);
         chk("rnd_state_b", o_state, 1);
         chk("rnd_valid_clr", o_valid, 0);
         if ($urandom_range(0, 1) == 1) begin
            press(BR);
            chk("rnd_ignored_run", o_state, 1);
         end
         sw = b; press(BB);
         chk("rnd_state_op", o_state, 2);
         ready = 1'b0;
         for (int t = 0; t < 2 && !ready; t++) begin
            op = ($urandom_range(0, 2) == 0) ? 6'($urandom) : codes[$urandom_range(0, 7)];
            sw = {2'($urandom), op}; press(BO);
            ready = supported(op);
            chk("rnd_error", o_error, !ready);
            chk("rnd_state_after_op", o_state, ready ? 3 : 2);
         end
         if (!ready) begin
            op = codes[$urandom_range(0, 7)];
            sw = {2'($urandom), op}; press(BO);
            chk("rnd_error_fix", o_error, 0);
         end
         exp_res = alu_ref(a, b, op);
         sw = 8'($urandom); press(BR);
         chk("rnd_result", o_result, exp_res);
         chk("rnd_valid", o_valid, 1);
         chk("rnd_cod", cod, op);
         if ($urandom_range(0, 1) == 1) begin
            sw = 8'($urandom); press(BR);
            chk("rnd_rerun", o_result, exp_res);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
